// File: rtl/mode_counter.sv
// mode_counter: up/down counter with a programmable inclusive limit and a
// synchronous load. At the end of the count it can wrap, saturate or stop
// once (one-shot). It also provides a terminal-count pulse, a sticky
// overflow flag and a registered compare match.
module mode_counter #(
  parameter int unsigned          WIDTH  = 32,
  parameter logic [WIDTH-1:0]     PRESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             cmp_match,
  output logic             running,
  output logic             done
);

  localparam logic [1:0] MODE_WRAP     = 2'd0;
  localparam logic [1:0] MODE_SATURATE = 2'd1;
  localparam logic [1:0] MODE_ONESHOT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             ovf_next;
  logic             oneshot;
  logic             step_ok;
  logic             boundary;

  // Decide whether this edge takes a step and whether that step hits the end of the range
  always_comb begin
    oneshot  = (mode == MODE_ONESHOT);
    step_ok  = en && (!oneshot || (state == RUN));
    boundary = down ? (q == '0) : (q >= limit);
  end

  // Next-value logic: reset is handled in the register block; here load beats step
  always_comb begin
    q_next     = q;
    tc_next    = 1'b0;
    ovf_next   = ovf & ~ovf_clr;
    state_next = oneshot ? state : IDLE;

    if (load) begin
      q_next = load_val;
      if (oneshot) begin
        state_next = RUN;
      end
    end else if (step_ok) begin
      if (boundary) begin
        tc_next  = 1'b1;
        ovf_next = 1'b1;
        case (mode)
          MODE_SATURATE: q_next = q;
          MODE_ONESHOT: begin
            q_next     = q;
            state_next = DONE;
          end
          default:       q_next = down ? limit : '0;
        endcase
      end else begin
        q_next = down ? (q - WIDTH'(1)) : (q + WIDTH'(1));
      end
    end
  end

  // All outputs are registered; cmp_match and the state flags are taken from next values
  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= PRESET;
      tc        <= 1'b0;
      ovf       <= 1'b0;
      cmp_match <= (PRESET == cmp_val);
      state     <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      q         <= q_next;
      tc        <= tc_next;
      ovf       <= ovf_next;
      cmp_match <= (q_next == cmp_val);
      state     <= state_next;
      running   <= (state_next == RUN);
      done      <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Directed testbench for mode_counter: an 8-bit instance for the main
// behaviour plus a 4-bit instance with a non-zero PRESET for width edges.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       reset, en, down, load, ovf_clr;
  logic [1:0] mode;
  logic [7:0] load_val, limit, cmp_val;
  logic [7:0] q;
  logic       tc, ovf, cmp_match, running, done;

  logic       reset4, en4, down4, load4, ovf_clr4;
  logic [1:0] mode4;
  logic [3:0] load_val4, limit4, cmp_val4;
  logic [3:0] q4;
  logic       tc4, ovf4, cmp_match4, running4, done4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(8), .PRESET(8'd0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .down(down), .mode(mode),
    .load(load), .load_val(load_val), .limit(limit), .cmp_val(cmp_val),
    .ovf_clr(ovf_clr), .q(q), .tc(tc), .ovf(ovf), .cmp_match(cmp_match),
    .running(running), .done(done)
  );

  mode_counter #(.WIDTH(4), .PRESET(4'd3)) u_dut4 (
    .clk(clk), .reset(reset4), .en(en4), .down(down4), .mode(mode4),
    .load(load4), .load_val(load_val4), .limit(limit4), .cmp_val(cmp_val4),
    .ovf_clr(ovf_clr4), .q(q4), .tc(tc4), .ovf(ovf4), .cmp_match(cmp_match4),
    .running(running4), .done(done4)
  );

  // one clock edge, then settle so outputs are sampled away from the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkMain(input string tag, input logic [7:0] eq, input logic etc, input logic eovf);
    checkOutput({tag, "_q"},   32'(q),   32'(eq));
    checkOutput({tag, "_tc"},  32'(tc),  32'(etc));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eovf));
  endtask

  logic [7:0] exp_q[6];
  logic       exp_tc[6];
  logic       exp_ovf[6];

  initial begin
    reset = 1; en = 0; down = 0; load = 0; ovf_clr = 0; mode = 2'd0;
    load_val = 0; limit = 0; cmp_val = 8'hAA;
    reset4 = 1; en4 = 0; down4 = 0; load4 = 0; ovf_clr4 = 0; mode4 = 2'd0;
    load_val4 = 0; limit4 = 0; cmp_val4 = 4'd3;

    // reset state
    applyStimulus();
    checkMain("rst", 8'd0, 1'b0, 1'b0);
    checkOutput("rst_cmp", 32'(cmp_match), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    // wrap up to limit 3
    reset = 0; limit = 8'd3; mode = 2'd0; en = 1;
    exp_q   = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2};
    exp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkMain($sformatf("wrap%0d", i), exp_q[i], exp_tc[i], exp_ovf[i]);
    end

    // saturate down from a loaded 2; load with ovf_clr clears ovf
    en = 0; mode = 2'd1; load = 1; load_val = 8'd2; ovf_clr = 1;
    applyStimulus();
    checkMain("sat_load", 8'd2, 1'b0, 1'b0);
    load = 0; ovf_clr = 0; down = 1; en = 1;
    exp_q[0:4]   = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_tc[0:4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_ovf[0:4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      ovf_clr = (i == 4);
      applyStimulus();
      checkMain($sformatf("sat%0d", i), exp_q[i], exp_tc[i], exp_ovf[i]);
    end
    en = 0; ovf_clr = 1;
    applyStimulus();
    checkMain("sat_clr", 8'd0, 1'b0, 1'b0);
    ovf_clr = 0;

    // one-shot: no counting before a load
    mode = 2'd2; down = 0; en = 1; limit = 8'd7;
    applyStimulus();
    applyStimulus();
    checkMain("os_idle", 8'd0, 1'b0, 1'b0);
    checkOutput("os_idle_running", 32'(running), 32'd0);
    load = 1; load_val = 8'd5;
    applyStimulus();
    checkMain("os_load", 8'd5, 1'b0, 1'b0);
    checkOutput("os_load_running", 32'(running), 32'd1);
    load = 0;
    applyStimulus();
    checkMain("os_6", 8'd6, 1'b0, 1'b0);
    applyStimulus();
    checkMain("os_7", 8'd7, 1'b0, 1'b0);
    applyStimulus();
    checkMain("os_end", 8'd7, 1'b1, 1'b1);
    checkOutput("os_end_done", 32'(done), 32'd1);
    checkOutput("os_end_running", 32'(running), 32'd0);
    applyStimulus();
    checkMain("os_hold", 8'd7, 1'b0, 1'b1);
    checkOutput("os_hold_done", 32'(done), 32'd1);
    load = 1; load_val = 8'd0;
    applyStimulus();
    checkOutput("os_reload_q", 32'(q), 32'd0);
    checkOutput("os_reload_running", 32'(running), 32'd1);
    checkOutput("os_reload_done", 32'(done), 32'd0);
    load = 0; mode = 2'd0; en = 0;
    applyStimulus();
    checkOutput("os_leave_running", 32'(running), 32'd0);

    // priority: reset beats load
    reset = 1; load = 1; load_val = 8'h55;
    applyStimulus();
    checkMain("pri_rst", 8'd0, 1'b0, 1'b0);
    reset = 0; limit = 8'd3; load_val = 8'd3;
    applyStimulus();
    load = 0; en = 1;
    applyStimulus();
    checkMain("pri_wrap", 8'd0, 1'b1, 1'b1);
    en = 0; load = 1;
    applyStimulus();
    // load beats a boundary step at q == limit
    en = 1; load_val = 8'd9;
    applyStimulus();
    checkMain("pri_load", 8'd9, 1'b0, 1'b1);
    // q above limit on an up step recovers to 0
    load = 0;
    applyStimulus();
    checkMain("above_limit", 8'd0, 1'b1, 1'b1);

    // compare match
    reset = 1; en = 0;
    applyStimulus();
    reset = 0; cmp_val = 8'd2; limit = 8'd5; en = 1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("cmp_q%0d", i), 32'(q), 32'(i));
      checkOutput($sformatf("cmp_m%0d", i), 32'(cmp_match), 32'(i == 2));
    end

    // limit 0: every up step is a boundary, q pinned at 0
    limit = 8'd0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkMain($sformatf("lim0_%0d", i), 8'd0, 1'b1, 1'b1);
    end
    down = 1;
    applyStimulus();
    checkMain("lim0_down", 8'd0, 1'b1, 1'b1);
    en = 0;
    applyStimulus();
    checkMain("en_off", 8'd0, 1'b0, 1'b1);

    // 4-bit instance: PRESET reset and full-range wrap both ways
    applyStimulus();
    checkOutput("w4_rst_q", 32'(q4), 32'd3);
    checkOutput("w4_rst_cmp", 32'(cmp_match4), 32'd1);
    reset4 = 0; limit4 = 4'd15; load4 = 1; load_val4 = 4'd15;
    applyStimulus();
    checkOutput("w4_load_q", 32'(q4), 32'd15);
    load4 = 0; en4 = 1;
    applyStimulus();
    checkOutput("w4_up_q", 32'(q4), 32'd0);
    checkOutput("w4_up_tc", 32'(tc4), 32'd1);
    down4 = 1;
    applyStimulus();
    checkOutput("w4_dn_q", 32'(q4), 32'd15);
    checkOutput("w4_dn_tc", 32'(tc4), 32'd1);
    applyStimulus();
    checkOutput("w4_dn2_q", 32'(q4), 32'd14);
    checkOutput("w4_dn2_tc", 32'(tc4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
